dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Purpose: single-port data-memory responder; word RAM plus an optional MMIO block (TOHOST/CYCLE/STORES/STATUS).
// Latency: reads are combinational (zero wait states); writes commit on the rising edge of clk.
// Backpressure: none; every access is accepted in the cycle it is presented.
//
// Optional feature macro: DMEM_RESPONDER_MMIO_EN
//   defined   -> dmem_addr[DADDR-1]=1 selects the MMIO register block
//   undefined -> the whole address space is RAM; tohost/tohost_valid tied low;
//                misalign_err is sticky until reset
//
// Ports:
//   clk, reset    single clock (rising edge), asynchronous active-high reset
//   dmem_addr     byte address from the core
//   dmem_wdata    store data, already lane-aligned
//   dmem_wr_en    byte-lane write enables; 4'b0000 is a read
//   dmem_rdata    combinational read data for dmem_addr
//   fin           core halted; freezes the cycle counter
//   tohost        last value written to TOHOST
//   tohost_valid  one-cycle pulse following each TOHOST write
//   misalign_err  sticky flag for an illegal byte-enable pattern
module dmem_responder #(
  parameter int WIDTH = 32,
  parameter int DADDR = 16,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic [3:0]       dmem_wr_en,
  output logic [WIDTH-1:0] dmem_rdata,
  input  logic             fin,
  output logic [WIDTH-1:0] tohost,
  output logic             tohost_valid,
  output logic             misalign_err
);

  localparam int LANE = WIDTH / 4;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  // Replace only the lanes whose enable bit is set.
  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [3:0]       en);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) res[i*LANE +: LANE] = new_w[i*LANE +: LANE];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode and enable legality
  // ---------------------------------------------------------------------------
  logic [31:0]      word_idx;
  logic [IW-1:0]    ram_idx;
  logic             en_legal;
  logic             wr_ok;
  logic             mmio_sel;
  logic             ram_we;
  logic             status_clr;
  logic [WIDTH-1:0] ram_rd;

  // Word index wraps onto the physical RAM, so aliases repeat every DEPTH words.
  assign word_idx = 32'(dmem_addr[DADDR-1:2]);
  assign ram_idx  = IW'(word_idx % DEPTH_U);

  // Only byte, aligned half-word and full-word patterns are accepted.
  always_comb begin
    case (dmem_wr_en)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: en_legal = 1'b1;
      default:                   en_legal = 1'b0;
    endcase
  end

  assign wr_ok  = en_legal && (dmem_wr_en != 4'b0000);
  assign ram_we = wr_ok && !mmio_sel;

  // ---------------------------------------------------------------------------
  // RAM: not reset, contents survive reset
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ram [DEPTH];

  assign ram_rd = ram[ram_idx];

  // The read port sees the stored word until the edge, giving read-before-write
  // behaviour for a same-cycle read and write of one word.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= merge_lanes(ram_rd, dmem_wdata, dmem_wr_en);
  end

  // ---------------------------------------------------------------------------
  // Sticky misalignment flag; a new illegal pattern beats a same-cycle clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (!en_legal) begin
      misalign_err <= 1'b1;
    end else if (status_clr) begin
      misalign_err <= 1'b0;
    end
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  // ---------------------------------------------------------------------------
  // MMIO register block
  // ---------------------------------------------------------------------------
  logic [1:0]       reg_sel;
  logic             tohost_we;
  logic [WIDTH-1:0] cycle_q;
  logic [WIDTH-1:0] stores_q;
  logic [WIDTH-1:0] mmio_rdata;

  assign mmio_sel   = dmem_addr[DADDR-1];
  assign reg_sel    = dmem_addr[3:2];
  assign tohost_we  = wr_ok && mmio_sel && (reg_sel == 2'd0);
  // STATUS is W1C on bit0; the bit lives in lane 0 so that lane must be enabled.
  assign status_clr = wr_ok && mmio_sel && (reg_sel == 2'd3) &&
                      dmem_wr_en[0] && dmem_wdata[0];

  // Writes to CYCLE and STORES fall through here with no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tohost       <= '0;
      tohost_valid <= 1'b0;
      cycle_q      <= '0;
      stores_q     <= '0;
    end else begin
      tohost_valid <= tohost_we;
      if (tohost_we) tohost <= merge_lanes(tohost, dmem_wdata, dmem_wr_en);
      if (!fin)      cycle_q  <= cycle_q + WIDTH'(1);
      if (ram_we)    stores_q <= stores_q + WIDTH'(1);
    end
  end

  // Counters read back their registered value, i.e. before this cycle's update.
  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      2'd0:    mmio_rdata = tohost;
      2'd1:    mmio_rdata = cycle_q;
      2'd2:    mmio_rdata = stores_q;
      default: mmio_rdata = {{(WIDTH-1){1'b0}}, misalign_err};
    endcase
  end

  assign dmem_rdata = mmio_sel ? mmio_rdata : ram_rd;
`else
  // ---------------------------------------------------------------------------
  // No MMIO: everything is RAM, host outputs are quiet
  // ---------------------------------------------------------------------------
  logic unused_fin;

  assign mmio_sel     = 1'b0;
  assign status_clr   = 1'b0;
  assign tohost       = '0;
  assign tohost_valid = 1'b0;
  assign dmem_rdata   = ram_rd;
  assign unused_fin   = fin;
`endif

  // Byte offset within the word does not affect the access.
  logic unused_addr;
  assign unused_addr = &{1'b0, dmem_addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: directed self-checking bench for dmem_responder (RAM path, lane writes, misalignment, MMIO).
// Latency: inputs driven on the falling edge, registered outputs sampled #1 after it.
// Backpressure: not applicable; the DUT accepts every access.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wr_en;
  logic [31:0] dmem_rdata;
  logic        fin;
  logic [31:0] tohost;
  logic        tohost_valid;
  logic        misalign_err;

  int n_cmp;
  int n_bad;

  dmem_responder #(
    .WIDTH (32),
    .DADDR (16),
    .DEPTH (1024)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_rdata   (dmem_rdata),
    .fin          (fin),
    .tohost       (tohost),
    .tohost_valid (tohost_valid),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one access for the coming rising edge.
  task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic [3:0] e);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_wr_en = e;
  endtask

  task automatic idle();
    @(negedge clk);
    dmem_wdata = '0;
    dmem_wr_en = 4'b0000;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wdata = '0;
    dmem_wr_en = 4'b0000;
    #1 chk(tag, dmem_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    fin        = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wr_en = 4'b0000;

    // Asynchronous reset: outputs clear before any clock edge arrives.
    #1 reset = 1'b1;
    #1;
    chk("rst_tohost",       tohost,               32'h0);
    chk("rst_tohost_valid", 32'(tohost_valid),    32'h0);
    chk("rst_misalign",     32'(misalign_err),    32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 100 rising edges with fin low, then freeze.
    repeat (100) @(posedge clk);
    #1 fin = 1'b1;
`ifdef DMEM_RESPONDER_MMIO_EN
    dmem_addr = 16'h8004;
    #1 chk("cycle_at_fin", dmem_rdata, 32'd100);
    repeat (5) @(posedge clk);
    #1 chk("cycle_frozen", dmem_rdata, 32'd100);
    dmem_addr = 16'h8008;
    #1 chk("stores_initial", dmem_rdata, 32'd0);
`endif

    // Five RAM stores, then MMIO-side writes and an illegal write.
    for (int i = 0; i < 5; i++) drive(16'h0100 + 16'(i * 4), 32'hA5A5_0000 + 32'(i), 4'b1111);
    drive(16'h8000, 32'h0000_0077, 4'b1111);
    drive(16'h8004, 32'hFFFF_FFFF, 4'b1111);
    drive(16'h8008, 32'h1234_5678, 4'b1111);
    drive(16'h0140, 32'h0000_0000, 4'b0101);
`ifdef DMEM_RESPONDER_MMIO_EN
    rd_check("stores_after5",       16'h8008, 32'd5);
    rd_check("cycle_write_ignored", 16'h8004, 32'd100);
    rd_check("tohost_reg_read",     16'h8000, 32'h0000_0077);
`else
    rd_check("alias_8000_word0", 16'h0000, 32'h0000_0077);
    chk("tohost_tied", tohost, 32'h0);
`endif
    chk("misalign_set_a", 32'(misalign_err), 32'h1);

    // Mid-run reset, asserted between clock edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst2_tohost",       tohost,            32'h0);
    chk("rst2_tohost_valid", 32'(tohost_valid), 32'h0);
    chk("rst2_misalign",     32'(misalign_err), 32'h0);
`ifdef DMEM_RESPONDER_MMIO_EN
    dmem_addr = 16'h8008;
    #1 chk("rst2_stores", dmem_rdata, 32'h0);
    dmem_addr = 16'h8004;
    #1 chk("rst2_cycle", dmem_rdata, 32'h0);
    dmem_addr = 16'h8000;
    #1 chk("rst2_tohost_reg", dmem_rdata, 32'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_check("ram_kept0", 16'h0100, 32'hA5A5_0000);
    rd_check("ram_kept1", 16'h0104, 32'hA5A5_0001);
    rd_check("ram_kept2", 16'h0108, 32'hA5A5_0002);
    rd_check("ram_kept3", 16'h010C, 32'hA5A5_0003);
    rd_check("ram_kept4", 16'h0110, 32'hA5A5_0004);

    // Byte-lane merges.
    drive(16'h0010, 32'hDEAD_BEEF, 4'b1111);
    drive(16'h0010, 32'h0000_00AA, 4'b0001);
    rd_check("lane0_merge", 16'h0010, 32'hDEAD_BEAA);

    drive(16'h0020, 32'hCAFE_F00D, 4'b1111);
    drive(16'h0020, 32'h1234_0000, 4'b1100);
    #1 chk("same_cycle_old", dmem_rdata, 32'hCAFE_F00D);
    rd_check("upper_half", 16'h0020, 32'h1234_F00D);

    drive(16'h0024, 32'h1122_3344, 4'b1111);
    drive(16'h0024, 32'h0000_AA00, 4'b0010);
    rd_check("lane1", 16'h0024, 32'h1122_AA44);
    drive(16'h0024, 32'h00BB_0000, 4'b0100);
    rd_check("lane2", 16'h0024, 32'h11BB_AA44);
    drive(16'h0024, 32'hCC00_0000, 4'b1000);
    rd_check("lane3", 16'h0024, 32'hCCBB_AA44);
    drive(16'h0024, 32'h0000_5566, 4'b0011);
    rd_check("low_half", 16'h0024, 32'hCCBB_5566);

    // Illegal enables: write dropped, flag set on the edge.
    drive(16'h0030, 32'h5555_5555, 4'b1111);
    drive(16'h0030, 32'hFFFF_FFFF, 4'b0110);
    #1 chk("misalign_pre_edge", 32'(misalign_err), 32'h0);
    rd_check("illegal_no_write", 16'h0030, 32'h5555_5555);
    chk("misalign_set", 32'(misalign_err), 32'h1);
    drive(16'h0030, 32'hFFFF_FFFF, 4'b1011);
    rd_check("illegal_no_write2", 16'h0030, 32'h5555_5555);

`ifdef DMEM_RESPONDER_MMIO_EN
    rd_check("status_set", 16'h800C, 32'h1);
    drive(16'h800C, 32'h0, 4'b1111);
    rd_check("status_w0_keeps", 16'h800C, 32'h1);
    drive(16'h800C, 32'h1, 4'b1111);
    idle();
    #1 chk("w1c_clear", 32'(misalign_err), 32'h0);
    drive(16'h800C, 32'h1, 4'b0111);
    idle();
    #1 chk("set_wins", 32'(misalign_err), 32'h1);
    drive(16'h800C, 32'hFFFF_FFFF, 4'b1111);
    rd_check("status_cleared", 16'h800C, 32'h0);

    // TOHOST pulse, back-to-back writes, illegal write.
    drive(16'h8000, 32'h0000_0001, 4'b1111);
    idle();
    #1;
    chk("tohost_val",   tohost,            32'h1);
    chk("tohost_pulse", 32'(tohost_valid), 32'h1);
    idle();
    #1 chk("tohost_pulse_end", 32'(tohost_valid), 32'h0);
    drive(16'h8000, 32'hAABB_CC02, 4'b1111);
    drive(16'h8000, 32'h0000_0003, 4'b0001);
    #1;
    chk("b2b_valid1",  32'(tohost_valid), 32'h1);
    chk("b2b_tohost1", tohost,            32'hAABB_CC02);
    idle();
    #1;
    chk("b2b_valid2",  32'(tohost_valid), 32'h1);
    chk("b2b_tohost2", tohost,            32'hAABB_CC03);
    idle();
    #1 chk("b2b_valid_end", 32'(tohost_valid), 32'h0);
    drive(16'h8000, 32'hFFFF_FFFF, 4'b1001);
    idle();
    #1;
    chk("tohost_illegal_valid", 32'(tohost_valid), 32'h0);
    chk("tohost_illegal_keep",  tohost,            32'hAABB_CC03);
    rd_check("stores_final", 16'h8008, 32'd10);
`else
    drive(16'h800C, 32'h1, 4'b1111);
    idle();
    #1 chk("sticky_no_mmio", 32'(misalign_err), 32'h1);
    drive(16'h8000, 32'h0000_0001, 4'b1111);
    idle();
    #1;
    chk("tohost_tied2",      tohost,            32'h0);
    chk("tohost_valid_tied", 32'(tohost_valid), 32'h0);
    rd_check("alias_word0_b", 16'h0000, 32'h0000_0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
